mem_access_ctrl: RTL and testbench

- Initiator side of the MOV/MOC memory handshake; sits in the CPU data path between the control unit and the byte-addressed RAM.
- Accepts one load/store request at a time and drives RAM address, size, R_W and DataIn, then MOV.
- Waits for MOC, captures and extends read data, and releases the handshake.
- Reports completion with a single-cycle done pulse, plus err for rejected or aborted accesses.

---
 rtl/mem_access_ctrl.sv | 179 +++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Initiator side of the MOV/MOC RAM handshake: one load/store at a time, read data extension.
// Optional MEM_TIMEOUT_EN aborts an access when MOC does not reach the awaited level in time.
`timescale 1ns/1ps

module mem_access_ctrl #(
  parameter int ADDR_W         = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              rw,
  input  logic [1:0]        size,
  input  logic              sign,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic              mem_mov,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        mem_size,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout,
  input  logic              mem_moc
);

  // state   | meaning
  // IDLE    | waiting for req; illegal requests answered here with done+err
  // SETUP   | address/size/R_W/DataIn stable one cycle before the strobe
  // ACCESS  | MOV high, waiting for MOC=1
  // RELEASE | MOV low, waiting for MOC=0 before reporting done
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RELEASE} state_t;

  state_t              state, state_n;
  logic                mem_mov_n, mem_rw_n, busy_n, done_n, err_n, sign_q, sign_n;
  logic [ADDR_W-1:0]   mem_addr_n;
  logic [1:0]          mem_size_n;
  logic [31:0]         mem_din_n, rdata_n, rdata_ext;
  logic                legal;
  logic                tmo_hit;

  always_comb begin
    legal = 1'b0;
    case (size)
      2'b00:   legal = 1'b1;
      2'b01:   legal = ~addr[0];
      2'b10:   legal = (addr[1:0] == 2'b00);
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    rdata_ext = mem_dout;
    case (mem_size)
      2'b00:   rdata_ext = {{24{sign_q & mem_dout[7]}},  mem_dout[7:0]};
      2'b01:   rdata_ext = {{16{sign_q & mem_dout[15]}}, mem_dout[15:0]};
      default: rdata_ext = mem_dout;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] tmo_cnt;
  logic             tmo_load;

  // Reload on every entry to a waiting state; terminal count reached means the wait expired.
  assign tmo_load = (state_n != state) && ((state_n == ACCESS) || (state_n == RELEASE));
  assign tmo_hit  = (tmo_cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      tmo_cnt <= '0;
    else if (tmo_load)
      tmo_cnt <= CNT_W'(TIMEOUT_CYCLES - 1);
    else if (tmo_cnt != '0)
      tmo_cnt <= tmo_cnt - 1'b1;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES > 0);
  assign tmo_hit        = 1'b0;
`endif

  always_comb begin
    state_n    = state;
    mem_mov_n  = mem_mov;
    mem_rw_n   = mem_rw;
    mem_addr_n = mem_addr;
    mem_size_n = mem_size;
    mem_din_n  = mem_din;
    sign_n     = sign_q;
    rdata_n    = rdata;
    busy_n     = busy;
    done_n     = 1'b0;
    err_n      = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (legal) begin
            mem_addr_n = addr;
            mem_size_n = size;
            mem_rw_n   = rw;
            mem_din_n  = wdata;
            sign_n     = sign;
            mem_mov_n  = 1'b0;
            busy_n     = 1'b1;
            state_n    = SETUP;
          end else begin
            done_n = 1'b1;
            err_n  = 1'b1;
          end
        end
      end
      SETUP: begin
        mem_mov_n = 1'b1;
        state_n   = ACCESS;
      end
      ACCESS: begin
        if (mem_moc) begin
          mem_mov_n = 1'b0;
          if (mem_rw)
            rdata_n = rdata_ext;
          state_n = RELEASE;
        end else if (tmo_hit) begin
          mem_mov_n = 1'b0;
          busy_n    = 1'b0;
          done_n    = 1'b1;
          err_n     = 1'b1;
          state_n   = IDLE;
        end
      end
      RELEASE: begin
        if (!mem_moc) begin
          busy_n  = 1'b0;
          done_n  = 1'b1;
          state_n = IDLE;
        end else if (tmo_hit) begin
          busy_n  = 1'b0;
          done_n  = 1'b1;
          err_n   = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      mem_mov  <= 1'b0;
      mem_rw   <= 1'b1;
      mem_addr <= '0;
      mem_size <= 2'b00;
      mem_din  <= '0;
      sign_q   <= 1'b0;
      rdata    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      mem_mov  <= mem_mov_n;
      mem_rw   <= mem_rw_n;
      mem_addr <= mem_addr_n;
      mem_size <= mem_size_n;
      mem_din  <= mem_din_n;
      sign_q   <= sign_n;
      rdata    <= rdata_n;
      busy     <= busy_n;
      done     <= done_n;
      err      <= err_n;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: vector table plus hand sequences for multi-cycle corners.
`timescale 1ns/1ps

module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, rw, sign;
  logic [1:0]  size;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic        busy, done, err;
  logic [31:0] rdata;
  logic        mem_mov, mem_rw, mem_moc;
  logic [7:0]  mem_addr;
  logic [1:0]  mem_size;
  logic [31:0] mem_din, mem_dout;

  int n_vec = 0;
  int n_err = 0;

  // Big-endian byte RAM responder; MOC follows MOV after moc_delay cycles.
  logic [7:0] ram [256];
  int         moc_delay = 0;
  int         moc_cnt   = 0;
  logic       moc_block = 1'b0;

  mem_access_ctrl #(.ADDR_W(8), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .req(req), .rw(rw), .size(size), .sign(sign),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err), .rdata(rdata),
    .mem_mov(mem_mov), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_size(mem_size),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_moc(mem_moc)
  );

  always #5 clk = ~clk;

  assign mem_moc = !moc_block && mem_mov && (moc_cnt >= moc_delay);

  always @(posedge clk) begin
    moc_cnt <= mem_mov ? moc_cnt + 1 : 0;
    if (mem_mov && mem_moc && !mem_rw) begin
      case (mem_size)
        2'b00: ram[mem_addr] <= mem_din[7:0];
        2'b01: begin
          ram[mem_addr]        <= mem_din[15:8];
          ram[mem_addr + 8'd1] <= mem_din[7:0];
        end
        default: begin
          ram[mem_addr]        <= mem_din[31:24];
          ram[mem_addr + 8'd1] <= mem_din[23:16];
          ram[mem_addr + 8'd2] <= mem_din[15:8];
          ram[mem_addr + 8'd3] <= mem_din[7:0];
        end
      endcase
    end
  end

  // Upper bits carry junk so extension must actually mask them.
  always_comb begin
    case (mem_size)
      2'b00:   mem_dout = {24'hA5A5A5, ram[mem_addr]};
      2'b01:   mem_dout = {16'h5A5A, ram[mem_addr], ram[mem_addr + 8'd1]};
      default: mem_dout = {ram[mem_addr], ram[mem_addr + 8'd1],
                           ram[mem_addr + 8'd2], ram[mem_addr + 8'd3]};
    endcase
  end

  typedef struct {
    logic        rw;
    logic [1:0]  size;
    logic        sign;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called one step after the accepting edge; counts edges until done is visible.
  task automatic wait_done(input bit pulse, output int lat, output int movs, output bit stable);
    bit         prev = 1'b0;
    bit         seen = 1'b0;
    logic [7:0] a0 = '0;
    logic       rw0 = 1'b0;
    logic [1:0] s0 = '0;
    logic [31:0] d0 = '0;
    lat = 0; movs = 0; stable = 1'b1;
    while (!done && lat < 40) begin
      if (mem_mov && !prev) movs++;
      if (mem_mov && !seen) begin
        seen = 1'b1; a0 = mem_addr; rw0 = mem_rw; s0 = mem_size; d0 = mem_din;
      end else if (seen && busy &&
                   (mem_addr !== a0 || mem_rw !== rw0 || mem_size !== s0 || mem_din !== d0))
        stable = 1'b0;
      prev = mem_mov;
      req  = pulse && busy && lat[0];
      if (req) begin
        addr = 8'h44; rw = ~rw; wdata = 32'h0F0F0F0F;
      end
      @(posedge clk) #1;
      lat++;
    end
    req = 1'b0;
    if (mem_mov && !prev) movs++;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat, movs;
    bit stable;
    req = 1'b1; rw = v.rw; size = v.size; sign = v.sign; addr = v.addr; wdata = v.wdata;
    @(posedge clk) #1;
    req = 1'b0;
    if (!v.exp_err) begin
      chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
      chk({tag, "_mem_addr"}, {24'b0, mem_addr}, {24'b0, v.addr});
      chk({tag, "_mem_din"}, mem_din, v.wdata);
      chk({tag, "_mem_rw"}, {31'b0, mem_rw}, {31'b0, v.rw});
    end
    wait_done(1'b0, lat, movs, stable);
    chk({tag, "_latency"}, lat, v.exp_err ? 32'd0 : 32'd3);
    chk({tag, "_err"}, {31'b0, err}, {31'b0, v.exp_err});
    chk({tag, "_rdata"}, rdata, v.exp_rdata);
    chk({tag, "_mov_count"}, movs, v.exp_err ? 32'd0 : 32'd1);
    chk({tag, "_addr_stable"}, {31'b0, stable}, 32'd1);
    @(posedge clk) #1;
    chk({tag, "_done_width"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    int  lat, movs;
    bit  stable, flag;
    vec_t v;

    reset = 1'b1; req = 1'b0; rw = 1'b0; size = 2'b00; sign = 1'b0; addr = '0; wdata = '0;

    //           rw    size   sg    addr   wdata          err   rdata
    vecs.push_back('{1'b0, 2'b00, 1'b0, 8'h21, 32'hFFFFFF80, 1'b0, 32'h00000000});
    vecs.push_back('{1'b0, 2'b10, 1'b0, 8'h10, 32'hDEADBEEF, 1'b0, 32'h00000000});
    vecs.push_back('{1'b1, 2'b10, 1'b0, 8'h10, 32'h00000000, 1'b0, 32'hDEADBEEF});
    vecs.push_back('{1'b1, 2'b00, 1'b1, 8'h21, 32'h00000000, 1'b0, 32'hFFFFFF80});
    vecs.push_back('{1'b1, 2'b00, 1'b0, 8'h21, 32'h00000000, 1'b0, 32'h00000080});
    vecs.push_back('{1'b1, 2'b01, 1'b0, 8'h21, 32'h00000000, 1'b1, 32'h00000080});
    vecs.push_back('{1'b1, 2'b11, 1'b0, 8'h20, 32'h00000000, 1'b1, 32'h00000080});
    vecs.push_back('{1'b0, 2'b10, 1'b0, 8'h12, 32'h11111111, 1'b1, 32'h00000080});
    vecs.push_back('{1'b0, 2'b01, 1'b0, 8'h40, 32'h00008001, 1'b0, 32'h00000080});
    vecs.push_back('{1'b1, 2'b01, 1'b1, 8'h40, 32'h00000000, 1'b0, 32'hFFFF8001});
    vecs.push_back('{1'b1, 2'b01, 1'b0, 8'h40, 32'h00000000, 1'b0, 32'h00008001});
    vecs.push_back('{1'b0, 2'b10, 1'b0, 8'hFC, 32'hA5A51234, 1'b0, 32'h00008001});
    vecs.push_back('{1'b1, 2'b10, 1'b0, 8'hFC, 32'h00000000, 1'b0, 32'hA5A51234});
    vecs.push_back('{1'b1, 2'b01, 1'b1, 8'hFE, 32'h00000000, 1'b0, 32'h00001234});
    vecs.push_back('{1'b1, 2'b00, 1'b1, 8'hFC, 32'h00000000, 1'b0, 32'hFFFFFFA5});
    vecs.push_back('{1'b0, 2'b10, 1'b0, 8'h00, 32'h0BADF00D, 1'b0, 32'hFFFFFFA5});
    vecs.push_back('{1'b1, 2'b00, 1'b0, 8'hFF, 32'h00000000, 1'b0, 32'h00000034});

    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_mov",  {31'b0, mem_mov}, 32'd0);
    chk("rst_mem_rw",   {31'b0, mem_rw},  32'd1);
    chk("rst_mem_addr", {24'b0, mem_addr}, 32'd0);
    chk("rst_mem_size", {30'b0, mem_size}, 32'd0);
    chk("rst_mem_din",  mem_din, 32'd0);
    chk("rst_rdata",    rdata, 32'd0);
    chk("rst_busy",     {31'b0, busy}, 32'd0);
    chk("rst_done_err", {30'b0, done, err}, 32'd0);
    reset = 1'b0;
    @(posedge clk) #1;

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("v%0d", i));

    // Request presented in the done cycle is accepted.
    req = 1'b1; rw = 1'b1; size = 2'b00; sign = 1'b0; addr = 8'h21;
    @(posedge clk) #1;
    req = 1'b0;
    wait_done(1'b0, lat, movs, stable);
    chk("b2b_first_done", {31'b0, done}, 32'd1);
    req = 1'b1; rw = 1'b1; size = 2'b10; sign = 1'b0; addr = 8'h10;
    @(posedge clk) #1;
    req = 1'b0;
    chk("b2b_second_busy", {31'b0, busy}, 32'd1);
    wait_done(1'b0, lat, movs, stable);
    chk("b2b_latency", lat, 32'd3);
    chk("b2b_rdata", rdata, 32'hDEADBEEF);

    // Slow responder with extra requests while busy.
    moc_delay = 5;
    req = 1'b1; rw = 1'b0; size = 2'b10; sign = 1'b0; addr = 8'h80; wdata = 32'h13579BDF;
    @(posedge clk) #1;
    req = 1'b0;
    wait_done(1'b1, lat, movs, stable);
    chk("slow_latency", lat, 32'd8);
    chk("slow_mov_count", movs, 32'd1);
    chk("slow_addr_stable", {31'b0, stable}, 32'd1);
    chk("slow_err", {31'b0, err}, 32'd0);
    flag = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk) #1;
      if (mem_mov || busy) flag = 1'b1;
    end
    chk("slow_no_queued_access", {31'b0, flag}, 32'd0);
    moc_delay = 0;
    v = '{1'b1, 2'b10, 1'b0, 8'h80, 32'h0, 1'b0, 32'h13579BDF};
    run_vec(v, "slow_readback");

    // Asynchronous reset while MOV is high.
    req = 1'b1; rw = 1'b1; size = 2'b10; sign = 1'b0; addr = 8'h10;
    @(posedge clk) #1;
    req = 1'b0;
    @(posedge clk) #1;
    chk("rstmid_mov_before", {31'b0, mem_mov}, 32'd1);
    #3 reset = 1'b1;
    #1;
    chk("rstmid_mov", {31'b0, mem_mov}, 32'd0);
    chk("rstmid_busy", {31'b0, busy}, 32'd0);
    chk("rstmid_done", {31'b0, done}, 32'd0);
    chk("rstmid_rdata", rdata, 32'd0);
    @(posedge clk) #1;
    reset = 1'b0;
    flag = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk) #1;
      if (done || mem_mov) flag = 1'b1;
    end
    chk("rstmid_no_done", {31'b0, flag}, 32'd0);
    v = '{1'b1, 2'b10, 1'b0, 8'h00, 32'h0, 1'b0, 32'h0BADF00D};
    run_vec(v, "post_reset_read");

`ifdef MEM_TIMEOUT_EN
    moc_block = 1'b1;
    req = 1'b1; rw = 1'b1; size = 2'b10; sign = 1'b0; addr = 8'h10;
    @(posedge clk) #1;
    req = 1'b0;
    wait_done(1'b0, lat, movs, stable);
    chk("tmo_latency", lat, 32'd17);
    chk("tmo_err", {31'b0, err}, 32'd1);
    chk("tmo_mov", {31'b0, mem_mov}, 32'd0);
    chk("tmo_busy", {31'b0, busy}, 32'd0);
    chk("tmo_rdata", rdata, 32'h0BADF00D);
    moc_block = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
